// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use hazard bubble and flush; optional bubble counter under ID_EX_BUBBLE_CNT_EN
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_stall,
    input  logic              in_flush,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_rsval,
    input  logic [DATA_W-1:0] in_rtval,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_ctrl_regwrt,
    input  logic              in_ctrl_memrd,
    input  logic              in_ctrl_memwrt,
    input  logic [3:0]        in_aluop,
    input  logic              in_wb_regwrt,
    input  logic [REG_AW-1:0] in_wb_rd,
    input  logic [DATA_W-1:0] in_wb_val,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_rsval,
    output logic [DATA_W-1:0] out_rtval,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_ctrl_regwrt,
    output logic              out_ctrl_memrd,
    output logic              out_ctrl_memwrt,
    output logic [3:0]        out_aluop,
    output logic              out_hazard
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0]       out_bubble_cnt
`endif
);

    logic [DATA_W-1:0] fwd_rsval;
    logic [DATA_W-1:0] fwd_rtval;
    logic              hold_rs_upd;
    logic              hold_rt_upd;

    // Load-use detection: a load in this stage whose destination the next instruction reads
    always_comb begin
        out_hazard = out_valid & out_ctrl_memrd & out_ctrl_regwrt & in_valid &
                     ((out_rd == in_rs) | (out_rd == in_rt));
    end

    // Capture-time bypass of the value the register file is writing this same edge
    always_comb begin
        fwd_rsval = in_rsval;
        fwd_rtval = in_rtval;
        if (in_wb_regwrt && (in_wb_rd == in_rs)) fwd_rsval = in_wb_val;
        if (in_wb_regwrt && (in_wb_rd == in_rt)) fwd_rtval = in_wb_val;
    end

    // While held, keep the stored operands coherent with writebacks that land meanwhile
    always_comb begin
        hold_rs_upd = out_valid & in_wb_regwrt & (in_wb_rd == out_rs);
        hold_rt_upd = out_valid & in_wb_regwrt & (in_wb_rd == out_rt);
    end

    // Stage register update: rst > flush > stall > hazard bubble > capture
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_rs          <= '0;
            out_rt          <= '0;
            out_rd          <= '0;
            out_rsval       <= '0;
            out_rtval       <= '0;
            out_imm         <= '0;
            out_ctrl_regwrt <= 1'b0;
            out_ctrl_memrd  <= 1'b0;
            out_ctrl_memwrt <= 1'b0;
            out_aluop       <= '0;
`ifdef ID_EX_BUBBLE_CNT_EN
            out_bubble_cnt  <= '0;
`endif
        end else if (in_flush) begin
            out_valid       <= 1'b0;
            out_ctrl_regwrt <= 1'b0;
            out_ctrl_memrd  <= 1'b0;
            out_ctrl_memwrt <= 1'b0;
            out_aluop       <= '0;
        end else if (in_stall) begin
            if (hold_rs_upd) out_rsval <= in_wb_val;
            if (hold_rt_upd) out_rtval <= in_wb_val;
        end else if (out_hazard) begin
            out_valid       <= 1'b0;
            out_ctrl_regwrt <= 1'b0;
            out_ctrl_memrd  <= 1'b0;
            out_ctrl_memwrt <= 1'b0;
            out_aluop       <= '0;
`ifdef ID_EX_BUBBLE_CNT_EN
            if (out_bubble_cnt != 16'hFFFF) out_bubble_cnt <= out_bubble_cnt + 16'd1;
`endif
        end else begin
            out_valid       <= in_valid;
            out_rs          <= in_rs;
            out_rt          <= in_rt;
            out_rd          <= in_rd;
            out_rsval       <= fwd_rsval;
            out_rtval       <= fwd_rtval;
            out_imm         <= in_imm;
            // Controls are qualified by valid so an empty slot never carries side effects
            out_ctrl_regwrt <= in_ctrl_regwrt & in_valid;
            out_ctrl_memrd  <= in_ctrl_memrd & in_valid;
            out_ctrl_memwrt <= in_ctrl_memwrt & in_valid;
            out_aluop       <= in_valid ? in_aluop : 4'd0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 6;

    logic              clk;
    logic              rst;
    logic              in_valid, in_stall, in_flush;
    logic [REG_AW-1:0] in_rs, in_rt, in_rd;
    logic [DATA_W-1:0] in_rsval, in_rtval, in_imm;
    logic              in_ctrl_regwrt, in_ctrl_memrd, in_ctrl_memwrt;
    logic [3:0]        in_aluop;
    logic              in_wb_regwrt;
    logic [REG_AW-1:0] in_wb_rd;
    logic [DATA_W-1:0] in_wb_val;
    logic              out_valid;
    logic [REG_AW-1:0] out_rs, out_rt, out_rd;
    logic [DATA_W-1:0] out_rsval, out_rtval, out_imm;
    logic              out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt;
    logic [3:0]        out_aluop;
    logic              out_hazard;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0]       out_bubble_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_stall(in_stall), .in_flush(in_flush),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_rsval(in_rsval), .in_rtval(in_rtval), .in_imm(in_imm),
        .in_ctrl_regwrt(in_ctrl_regwrt), .in_ctrl_memrd(in_ctrl_memrd),
        .in_ctrl_memwrt(in_ctrl_memwrt), .in_aluop(in_aluop),
        .in_wb_regwrt(in_wb_regwrt), .in_wb_rd(in_wb_rd), .in_wb_val(in_wb_val),
        .out_valid(out_valid), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_rsval(out_rsval), .out_rtval(out_rtval), .out_imm(out_imm),
        .out_ctrl_regwrt(out_ctrl_regwrt), .out_ctrl_memrd(out_ctrl_memrd),
        .out_ctrl_memwrt(out_ctrl_memwrt), .out_aluop(out_aluop),
        .out_hazard(out_hazard)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .out_bubble_cnt(out_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                         input logic [REG_AW-1:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic rw, input logic mr, input logic [3:0] op);
        in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd;
        in_rsval = rsv; in_rtval = rtv; in_imm = 32'h33;
        in_ctrl_regwrt = rw; in_ctrl_memrd = mr; in_ctrl_memwrt = 1'b0; in_aluop = op;
    endtask

    task automatic wb(input logic w, input logic [REG_AW-1:0] rd, input logic [31:0] val);
        in_wb_regwrt = w; in_wb_rd = rd; in_wb_val = val;
    endtask

    initial begin
        // Reset with every input nonzero
        rst = 1'b1; in_stall = 1'b1; in_flush = 1'b1;
        in_valid = 1'b1; in_rs = 6'h3F; in_rt = 6'h2A; in_rd = 6'h15;
        in_rsval = 32'hFFFF_FFFF; in_rtval = 32'h1234_5678; in_imm = 32'hDEAD_BEEF;
        in_ctrl_regwrt = 1'b1; in_ctrl_memrd = 1'b1; in_ctrl_memwrt = 1'b1; in_aluop = 4'hF;
        wb(1'b1, 6'h3F, 32'hCAFE_F00D);
        step();
        check("rst_valid", out_valid, 0);
        check("rst_rs", out_rs, 0);
        check("rst_rd", out_rd, 0);
        check("rst_rsval", out_rsval, 0);
        check("rst_imm", out_imm, 0);
        check("rst_ctrl", {out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt}, 0);
        check("rst_aluop", out_aluop, 0);
        check("rst_hazard", out_hazard, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("rst_bcnt", out_bubble_cnt, 0);
`endif

        // Forwarding on capture: rs matches writeback, rt does not
        rst = 1'b0; in_stall = 1'b0; in_flush = 1'b0;
        drive(1'b1, 6'd5, 6'd6, 6'd3, 32'h11, 32'h22, 1'b1, 1'b0, 4'd2);
        wb(1'b1, 6'd5, 32'hAB);
        step();
        check("fwd_rsval", out_rsval, 32'hAB);
        check("fwd_rtval", out_rtval, 32'h22);
        check("fwd_rd", out_rd, 3);
        check("fwd_valid", out_valid, 1);
        check("fwd_aluop", out_aluop, 2);
        check("fwd_imm", out_imm, 32'h33);

        // Load-use: load rd=7 in stage, next instruction reads rt=7
        drive(1'b1, 6'd1, 6'd2, 6'd7, 32'h1, 32'h2, 1'b1, 1'b1, 4'd0);
        wb(1'b0, 6'd0, 32'h0);
        step();
        drive(1'b1, 6'd4, 6'd7, 6'd8, 32'h44, 32'h77, 1'b1, 1'b0, 4'd3);
        #1;
        check("lu_hazard", out_hazard, 1);
        step();
        check("lu_bub_valid", out_valid, 0);
        check("lu_bub_ctrl", {out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt}, 0);
        check("lu_bub_aluop", out_aluop, 0);
        check("lu_bub_hazard", out_hazard, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("lu_bcnt", out_bubble_cnt, 1);
`endif
        wb(1'b1, 6'd7, 32'h99);
        step();
        check("lu_cap_valid", out_valid, 1);
        check("lu_cap_rd", out_rd, 8);
        check("lu_cap_rtval", out_rtval, 32'h99);
        check("lu_cap_rsval", out_rsval, 32'h44);
        check("lu_cap_aluop", out_aluop, 3);

        // Stall with writeback to the held rt
        drive(1'b1, 6'd10, 6'd9, 6'd11, 32'h10, 32'h12, 1'b1, 1'b0, 4'd5);
        wb(1'b0, 6'd0, 32'h0);
        step();
        in_stall = 1'b1;
        drive(1'b1, 6'd1, 6'd2, 6'd3, 32'hA1, 32'hA2, 1'b0, 1'b1, 4'd1);
        wb(1'b1, 6'd9, 32'h55);
        step();
        check("st_valid", out_valid, 1);
        check("st_rt", out_rt, 9);
        check("st_rd", out_rd, 11);
        check("st_aluop", out_aluop, 5);
        check("st_rtval", out_rtval, 32'h55);
        check("st_rsval", out_rsval, 32'h10);
        check("st_memrd", out_ctrl_memrd, 0);

        // Stall while a load-use hazard is pending: hold, no bubble
        in_stall = 1'b0;
        drive(1'b1, 6'd1, 6'd2, 6'd7, 32'h1, 32'h2, 1'b1, 1'b1, 4'd0);
        wb(1'b0, 6'd0, 32'h0);
        step();
        in_stall = 1'b1;
        drive(1'b1, 6'd7, 6'd3, 6'd4, 32'h5, 32'h6, 1'b1, 1'b0, 4'd6);
        step();
        check("sh_valid", out_valid, 1);
        check("sh_memrd", out_ctrl_memrd, 1);
        check("sh_hazard", out_hazard, 1);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("sh_bcnt", out_bubble_cnt, 1);
`endif

        // Flush overrides stall
        in_flush = 1'b1;
        step();
        check("fl_valid", out_valid, 0);
        check("fl_ctrl", {out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt}, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("fl_bcnt", out_bubble_cnt, 1);
`endif

        // Empty slot with controls asserted must not carry them
        in_flush = 1'b0; in_stall = 1'b0;
        drive(1'b0, 6'd12, 6'd13, 6'd14, 32'h7, 32'h8, 1'b1, 1'b1, 4'd9);
        step();
        check("iv_valid", out_valid, 0);
        check("iv_ctrl", {out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt}, 0);

        // Reset during stall abandons the held instruction; next edge captures normally
        drive(1'b1, 6'd20, 6'd21, 6'd22, 32'hB0, 32'hB1, 1'b1, 1'b0, 4'd4);
        step();
        in_stall = 1'b1; rst = 1'b1;
        step();
        check("rs_valid", out_valid, 0);
        rst = 1'b0; in_stall = 1'b0;
        drive(1'b1, 6'd30, 6'd31, 6'd63, 32'hC0, 32'hC1, 1'b1, 1'b0, 4'd7);
        step();
        check("rs_cap_rd", out_rd, 63);
        check("rs_cap_rtval", out_rtval, 32'hC1);

`ifdef ID_EX_BUBBLE_CNT_EN
        // Saturation: a self-dependent load alternates bubble/capture
        drive(1'b1, 6'd40, 6'd41, 6'd40, 32'h0, 32'h0, 1'b1, 1'b1, 4'd0);
        wb(1'b0, 6'd0, 32'h0);
        for (int i = 0; i < 65540 * 2; i++) begin
            @(posedge clk);
        end
        #1;
        check("sat_bcnt", out_bubble_cnt, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
